// File: rtl/datapath_driver.sv
// Command initiator for the ALU datapath: accepts one request, drives the datapath
// for its fixed latency, captures the result and flags, and returns them as a response.
module datapath_driver #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DP_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [5:0]           req_cmd,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic [WIDTH-1:0]     req_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_error,
    output logic                 busy,
    output logic [7:0]           err_count,
    output logic [5:0]           dp_cmd,
    output logic [WIDTH-1:0]     dp_din_1,
    output logic [WIDTH-1:0]     dp_din_2,
    output logic [WIDTH-1:0]     dp_din_3,
    input  logic [WIDTH-1:0]     dp_dout_low,
    input  logic [WIDTH-1:0]     dp_dout_high,
    input  logic                 dp_zero,
    input  logic                 dp_error
);

    localparam int unsigned CNT_W = $clog2(DP_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DP_LATENCY - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic [5:0]         dp_cmd_q, dp_cmd_d;
    logic [WIDTH-1:0]   dp_din_1_q, dp_din_1_d;
    logic [WIDTH-1:0]   dp_din_2_q, dp_din_2_d;
    logic [WIDTH-1:0]   dp_din_3_q, dp_din_3_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_error_q, rsp_error_d;
    logic [7:0]         err_count_q, err_count_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        dp_cmd_d    = dp_cmd_q;
        dp_din_1_d  = dp_din_1_q;
        dp_din_2_d  = dp_din_2_q;
        dp_din_3_d  = dp_din_3_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_error_d = rsp_error_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    state_d     = DRIVE;
                    req_ready_d = 1'b0;
                    cnt_d       = CNT_LOAD;
                    dp_cmd_d    = req_cmd;
                    dp_din_1_d  = req_a;
                    dp_din_2_d  = req_b;
                    dp_din_3_d  = req_c;
                end
            end
            DRIVE: begin
                req_ready_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {dp_dout_high, dp_dout_low};
                    rsp_zero_d  = dp_zero;
                    rsp_error_d = dp_error;
                    dp_cmd_d    = 6'd0;
                    dp_din_1_d  = '0;
                    dp_din_2_d  = '0;
                    dp_din_3_d  = '0;
                    if (dp_error && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                req_ready_d = 1'b0;
                // Response data is held after the handshake; only valid drops
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
                dp_cmd_d    = 6'd0;
                dp_din_1_d  = '0;
                dp_din_2_d  = '0;
                dp_din_3_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            dp_cmd_q    <= 6'd0;
            dp_din_1_q  <= '0;
            dp_din_2_q  <= '0;
            dp_din_3_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_error_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            dp_cmd_q    <= dp_cmd_d;
            dp_din_1_q  <= dp_din_1_d;
            dp_din_2_q  <= dp_din_2_d;
            dp_din_3_q  <= dp_din_3_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_error_q <= rsp_error_d;
            err_count_q <= err_count_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign dp_cmd    = dp_cmd_q;
    assign dp_din_1  = dp_din_1_q;
    assign dp_din_2  = dp_din_2_q;
    assign dp_din_3  = dp_din_3_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_error = rsp_error_q;
    assign err_count = err_count_q;

endmodule
